// File: rtl/spi_slv_frm_rx_if.sv
// SPI pin bundle plus committed-frame outputs of the SPI slave frame receiver.
// The master modport drives the SPI pins; the slave modport is the receiver side.
interface spi_slv_frm_rx_if #(
  parameter int unsigned FRM_W = 24
);
  logic             sclk;
  logic             csb;
  logic             mosi;
  logic             miso;
  logic             frm_vld;
  logic [FRM_W-9:0] frm_data;
  logic [7:0]       frm_crc;
  logic             crc_err;
  logic             len_err;

  modport master (
    output sclk, csb, mosi,
    input  miso, frm_vld, frm_data, frm_crc, crc_err, len_err
  );

  modport slave (
    input  sclk, csb, mosi,
    output miso, frm_vld, frm_data, frm_crc, crc_err, len_err
  );
endinterface

// File: rtl/spi_slv_frm_rx.sv
// SPI slave frame receiver: oversamples the SPI pins, deserializes payload+CRC-8 frames,
// checks length and CRC, and commits one frame per chip-select window.
module spi_slv_frm_rx #(
  parameter int unsigned MODE        = 0,
  parameter int unsigned FRM_W       = 24,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CRC_POLY    = 8'h07,
  parameter int unsigned MAX_FRM     = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  spi_slv_frm_rx_if.slave bus
);

  localparam int unsigned BitW    = $clog2(FRM_W);
  localparam int unsigned FrmCntW = $clog2(MAX_FRM + 1);
  localparam int unsigned PayW    = FRM_W - 8;

  typedef enum logic [1:0] {StIdle, StShift, StCheck, StWaitHi} state_e;

  // Synchronizers are deliberately not reset so they keep tracking the pins during reset.
  logic [SYNC_STAGES-1:0] sclk_sync_q, csb_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, csb_prev_q;

  always_ff @(posedge clk_i) begin
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], bus.csb};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    csb_prev_q  <= csb_sync_q[SYNC_STAGES-1];
  end

  logic sclk_s, csb_s, mosi_s;
  logic sclk_rise, sclk_fall, csb_rise, csb_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csb_s     = csb_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csb_rise  = csb_s & ~csb_prev_q;
  assign csb_fall  = ~csb_s & csb_prev_q;

  state_e             state_q;
  logic [FRM_W-1:0]   sr_q;
  logic [BitW-1:0]    bit_cnt_q;
  logic [FrmCntW-1:0] frm_cnt_q;
  logic               sat_q;
  logic               vld_q;
  logic [PayW-1:0]    data_q;
  logic [7:0]         crc_q;
  logic               crc_err_q;
  logic               len_err_q;
  logic               miso_q;

  logic [7:0] crc_calc;
  always_comb begin
    crc_calc = 8'h00;
    for (int i = FRM_W - 1; i >= 8; i--) begin
      crc_calc = {crc_calc[6:0], 1'b0} ^ ((crc_calc[7] ^ sr_q[i]) ? CRC_POLY : 8'h00);
    end
  end

  logic len_ok;
  always_comb begin
    len_ok = (bit_cnt_q == '0);
    if (MODE == 0) begin
      len_ok = len_ok && (frm_cnt_q == FrmCntW'(1));
    end else begin
      len_ok = len_ok && (frm_cnt_q != '0) && !sat_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      frm_cnt_q <= '0;
      sat_q     <= 1'b0;
      vld_q     <= 1'b0;
      data_q    <= '0;
      crc_q     <= '0;
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (csb_fall) begin
            state_q   <= StShift;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            frm_cnt_q <= '0;
            sat_q     <= 1'b0;
          end else if (!csb_s) begin
            // Low without a seen fall: we joined mid-window (e.g. after reset), drop it.
            state_q <= StWaitHi;
          end
        end
        StShift: begin
          if (csb_rise) begin
            state_q <= StCheck;
          end else if (sclk_rise) begin
            sr_q <= {sr_q[FRM_W-2:0], mosi_s};
            if (bit_cnt_q == BitW'(FRM_W - 1)) begin
              bit_cnt_q <= '0;
              if (frm_cnt_q == FrmCntW'(MAX_FRM)) begin
                sat_q <= 1'b1;
              end else begin
                frm_cnt_q <= frm_cnt_q + FrmCntW'(1);
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end
        end
        StCheck: begin
          vld_q   <= 1'b1;
          state_q <= StIdle;
          if (len_ok) begin
            data_q    <= sr_q[FRM_W-1:8];
            crc_q     <= sr_q[7:0];
            crc_err_q <= (crc_calc != sr_q[7:0]);
            len_err_q <= 1'b0;
          end else begin
            crc_err_q <= 1'b0;
            len_err_q <= 1'b1;
          end
        end
        StWaitHi: begin
          if (csb_s) state_q <= StIdle;
        end
      endcase

      // Daisy-chain forward: the oldest bit leaves on each sclk fall, an FRM_W-bit delay line.
      if (csb_s) begin
        miso_q <= 1'b0;
      end else if ((MODE == 1) && (state_q == StShift) && sclk_fall) begin
        miso_q <= sr_q[FRM_W-1];
      end
    end
  end

  assign bus.miso     = miso_q;
  assign bus.frm_vld  = vld_q;
  assign bus.frm_data = data_q;
  assign bus.frm_crc  = crc_q;
  assign bus.crc_err  = crc_err_q;
  assign bus.len_err  = len_err_q;

endmodule
